// File: rtl/spi_tx_arbiter_if.sv
// SPI slave transmit bus shared by the data sources and the MISO pad.
// The master side drives SSEL/SCK and source data; the slave side transmits.
interface spi_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic                 SSEL;
  logic                 SCK;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   data;
  logic [NREQ-1:0]      grant;
  logic                 abort;
  logic                 busy;
  logic                 miso_o;
  logic                 miso_oe;

  modport master (
    output SSEL, SCK, req, data,
    input  grant, abort, busy, miso_o, miso_oe
  );

  modport slave (
    input  SSEL, SCK, req, data,
    output grant, abort, busy, miso_o, miso_oe
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter that loads one source word per SSEL frame and
// shifts {valid, id, data} out on MISO, one bit per SCK falling edge.
module spi_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_tx_arbiter_if.slave   bus
);
  localparam int FL = 1 + IDW + DW;
  localparam int CW = $clog2(FL + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;

  // [0],[1] synchronizer, [2] history
  logic [2:0]      ssel_sync;
  logic [2:0]      sck_sync;
  logic            ssel_fall;
  logic            ssel_rise;
  logic            sck_fall;

  logic [IDW-1:0]  ptr;
  logic [FL-1:0]   shreg;
  logic [CW-1:0]   bitcnt;
  logic            abort_q;

  logic            win_vld;
  logic [IDW-1:0]  win;
  logic [NREQ-1:0] grant_w;
  int              idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssel_sync <= '0;
      sck_sync  <= '0;
    end else begin
      ssel_sync <= {ssel_sync[1:0], bus.SSEL};
      sck_sync  <= {sck_sync[1:0], bus.SCK};
    end
  end

  assign ssel_fall = ssel_sync[2] & ~ssel_sync[1];
  assign ssel_rise = ~ssel_sync[2] & ssel_sync[1];
  assign sck_fall  = sck_sync[2] & ~sck_sync[1];

  // first requester above the last winner, wrapping
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win     = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (ssel_fall) state_nx = LOAD;
      end
      LOAD: begin
        state_nx = ssel_rise ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (ssel_rise) begin
          state_nx = IDLE;
        end else if (sck_fall && bitcnt == CW'(FL - 1)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (ssel_rise) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= IDW'(NREQ - 1);
      shreg   <= '0;
      bitcnt  <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= ssel_rise && (state == LOAD || state == SHIFT);
      if (state == LOAD) begin
        bitcnt <= '0;
        if (win_vld) begin
          ptr   <= win;
          shreg <= {1'b1, win, bus.data[win*DW +: DW]};
        end else begin
          shreg <= '0;
        end
      end else if (state == SHIFT && !ssel_rise && sck_fall) begin
        shreg  <= {shreg[FL-2:0], 1'b0};
        bitcnt <= bitcnt + CW'(1);
      end
    end
  end

  always_comb begin
    grant_w = '0;
    if (state == LOAD && win_vld) grant_w[win] = 1'b1;
  end

  assign bus.grant   = grant_w;
  assign bus.abort   = abort_q;
  assign bus.busy    = (state != IDLE);
  assign bus.miso_oe = (state == SHIFT) || (state == DONE);
  assign bus.miso_o  = (state == SHIFT) & shreg[FL-1];

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: frame table with a grant scoreboard,
// plus abort, same-cycle edge and mid-frame reset sequences.
module tb_spi_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IDW  = 2;
  localparam int FL   = 1 + IDW + DW;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  spi_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  spi_tx_arbiter #(
    .NREQ(NREQ),
    .DW  (DW),
    .IDW (IDW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
  } vec_t;

  vec_t            tbl[8];
  logic [NREQ-1:0] exp_gnt_q[$];
  int              checks = 0;
  int              errors = 0;
  int              abort_cnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FL-1:0] exp_frame(logic [NREQ-1:0] g);
    int id;
    logic [NREQ*DW-1:0] d;
    id = -1;
    d  = bus.data;
    for (int i = 0; i < NREQ; i++) if (g[i]) id = i;
    if (id < 0) return '0;
    return {1'b1, id[IDW-1:0], d[id*DW +: DW]};
  endfunction

  always @(negedge clk) begin
    if (bus.abort === 1'b1) begin
      abort_cnt++;
      check("abort_vs_grant", 32'(bus.grant), 32'd0);
      check("abort_oe", 32'(bus.miso_oe), 32'd0);
    end
    if (bus.grant !== '0) begin
      if (exp_gnt_q.size() == 0) begin
        check("unexpected_grant", 32'(bus.grant), 32'd0);
      end else begin
        check("grant", 32'(bus.grant), 32'(exp_gnt_q.pop_front()));
      end
    end
  end

  task automatic clks(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame(logic [NREQ-1:0] r, logic [NREQ-1:0] g);
    bus.req = r;
    if (g != '0) exp_gnt_q.push_back(g);
    clks(2);
    bus.SSEL = 1'b0;
    clks(8);
  endtask

  // host samples MISO just before each rising SCK (mode 0)
  task automatic shift_bits(int n, output logic [FL-1:0] w);
    w = '0;
    for (int k = 0; k < n; k++) begin
      w = {w[FL-2:0], bus.miso_o};
      bus.SCK = 1'b1;
      clks(6);
      bus.SCK = 1'b0;
      clks(6);
    end
  endtask

  task automatic run_frame(logic [NREQ-1:0] r, logic [NREQ-1:0] g);
    logic [FL-1:0] w;
    int a0;
    a0 = abort_cnt;
    start_frame(r, g);
    check("oe_on", 32'(bus.miso_oe), 32'd1);
    shift_bits(FL, w);
    check("frame", 32'(w), 32'(exp_frame(g)));
    check("done_oe_miso", 32'({bus.miso_oe, bus.miso_o}), 32'b10);
    clks(6);
    check("done_hold", 32'({bus.miso_oe, bus.miso_o}), 32'b10);
    bus.SSEL = 1'b1;
    clks(8);
    check("idle_busy_oe", 32'({bus.busy, bus.miso_oe}), 32'd0);
    check("no_abort", 32'(abort_cnt - a0), 32'd0);
    check("grant_seen", 32'(exp_gnt_q.size()), 32'd0);
  endtask

  task automatic wait_abort(int a0);
    for (int i = 0; i < 12; i++) begin
      if (abort_cnt != a0) break;
      clks(1);
    end
    check("abort_pulse", 32'(abort_cnt - a0), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [FL-1:0] w;
    int a0;

    tbl[0] = '{req: 4'b1111, gnt: 4'b0001};
    tbl[1] = '{req: 4'b1111, gnt: 4'b0010};
    tbl[2] = '{req: 4'b1111, gnt: 4'b0100};
    tbl[3] = '{req: 4'b1111, gnt: 4'b1000};
    tbl[4] = '{req: 4'b1111, gnt: 4'b0001};
    tbl[5] = '{req: 4'b0100, gnt: 4'b0100};
    tbl[6] = '{req: 4'b0000, gnt: 4'b0000};
    tbl[7] = '{req: 4'b0001, gnt: 4'b0001};

    rst_n    = 1'b0;
    bus.SSEL = 1'b0;
    bus.SCK  = 1'b0;
    bus.req  = '0;
    bus.data = {8'h3C, 8'hA5, 8'h96, 8'h5A};
    clks(3);
    check("reset_outs",
          32'({bus.grant, bus.abort, bus.busy, bus.miso_o, bus.miso_oe}),
          32'd0);
    rst_n = 1'b1;
    clks(10);
    check("no_frame_after_reset", 32'({bus.busy, bus.miso_oe}), 32'd0);
    bus.SSEL = 1'b1;
    clks(6);

    for (int i = 0; i < 8; i++) run_frame(tbl[i].req, tbl[i].gnt);

    // abort after 4 bits; word of source 1 is consumed
    a0 = abort_cnt;
    start_frame(4'b1111, 4'b0010);
    shift_bits(4, w);
    check("abort_bits", 32'(w[3:0]), 32'b1011);
    bus.SSEL = 1'b1;
    wait_abort(a0);
    clks(4);
    check("abort_idle", 32'({bus.busy, bus.miso_oe}), 32'd0);
    check("abort_grant_seen", 32'(exp_gnt_q.size()), 32'd0);
    run_frame(4'b1111, 4'b0100);

    // SSEL rise together with the last SCK fall
    a0 = abort_cnt;
    start_frame(4'b1111, 4'b1000);
    shift_bits(FL - 1, w);
    bus.SCK = 1'b1;
    clks(6);
    bus.SCK  = 1'b0;
    bus.SSEL = 1'b1;
    wait_abort(a0);
    clks(4);
    check("race_idle", 32'({bus.busy, bus.miso_oe}), 32'd0);

    // reset in the middle of a shift
    start_frame(4'b1111, 4'b0001);
    shift_bits(3, w);
    #2;
    rst_n = 1'b0;
    #1;
    check("midshift_reset",
          32'({bus.grant, bus.abort, bus.busy, bus.miso_o, bus.miso_oe}),
          32'd0);
    clks(2);
    rst_n = 1'b1;
    clks(10);
    check("no_frame_after_reset2", 32'({bus.busy, bus.miso_oe}), 32'd0);
    bus.SSEL = 1'b1;
    clks(6);
    run_frame(4'b1111, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
